// File: rtl/muxn_pipelined_pkg.sv
// muxn_pipelined_pkg: elaboration-time helpers shared by the pipelined mux.
//   clog2(n)             - ceil(log2(n)), 0 for n <= 1
//   num_stages(n, lps)   - register stages for an n-way tree with lps levels per stage
//   padded_n(n)          - tree width after padding n up to a power of two
package muxn_pipelined_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Always at least one stage so the output is registered even for N=1.
    function automatic int num_stages(input int n, input int lps);
        int s;
        s = (clog2(n) + lps - 1) / lps;
        return (s < 1) ? 1 : s;
    endfunction

    function automatic int padded_n(input int n);
        return 1 << clog2(n);
    endfunction

endpackage

// File: rtl/muxn_pipe_stage.sv
// muxn_pipe_stage: one register stage of the pipelined mux tree.
// Reduces IN_N words to IN_N >> LEVELS words through LEVELS 2:1 levels, using
// the low LEVELS bits of up_sel, then registers the reduced vector together
// with the unconsumed sel bits, the err flag and valid.
// Ports:
//   clk, arst, flush             - clock, async active-high reset, valid clear
//   up_data/up_sel/up_err        - partial vector from the previous stage
//   up_valid, up_ready           - upstream handshake (up_ready is combinational)
//   dn_data/dn_sel/dn_err        - registered partial vector for the next stage
//   dn_valid, dn_ready           - downstream handshake
module muxn_pipe_stage #(
    parameter int IN_N     = 2,
    parameter int WIDTH    = 32,
    parameter int LEVELS   = 1,
    parameter int SELW_IN  = 1,
    parameter int SELW_OUT = 1
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic                              flush,
    input  logic [IN_N*WIDTH-1:0]             up_data,
    input  logic [SELW_IN-1:0]                up_sel,
    input  logic                              up_err,
    input  logic                              up_valid,
    output logic                              up_ready,
    output logic [(IN_N>>LEVELS)*WIDTH-1:0]   dn_data,
    output logic [SELW_OUT-1:0]               dn_sel,
    output logic                              dn_err,
    output logic                              dn_valid,
    input  logic                              dn_ready
);

    localparam int OUT_N = IN_N >> LEVELS;

    logic [IN_N*WIDTH-1:0] tree;
    logic [SELW_IN-1:0]    sel_rest;
    logic                  load;

    // Reduce in place: slot i of level j+1 only reads slots 2i and 2i+1 of
    // level j, which have not been overwritten yet when slot i is written.
    always_comb begin
        tree = up_data;
        for (int j = 0; j < LEVELS; j++) begin
            for (int i = 0; i < (IN_N >> (j + 1)); i++) begin
                tree[i*WIDTH +: WIDTH] = up_sel[j] ? tree[(2*i+1)*WIDTH +: WIDTH]
                                                   : tree[(2*i)*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_rest = up_sel >> LEVELS;

    // Bubble-collapsing ready: an empty stage accepts regardless of downstream.
    assign up_ready = !dn_valid || dn_ready;
    assign load     = up_ready && up_valid && !flush;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_sel   <= '0;
            dn_err   <= 1'b0;
        end else begin
            if (flush)
                dn_valid <= 1'b0;
            else if (up_ready)
                dn_valid <= up_valid;
            if (load) begin
                dn_data <= tree[OUT_N*WIDTH-1:0];
                dn_sel  <= sel_rest[SELW_OUT-1:0];
                dn_err  <= up_err;
            end
        end
    end

endmodule

// File: rtl/muxn_pipelined.sv
// muxn_pipelined: N-way, WIDTH-bit selector as an LSB-first binary tree of 2:1
// levels, LEVELS_PER_STAGE levels per register stage, with a valid/ready
// elastic handshake. Out-of-range selects resolve to in_data[N-1] and raise
// out_err alongside the word.
// Ports:
//   clk, arst           - clock, asynchronous active-high reset
//   flush               - synchronous clear of all in-flight valids
//   in_data[N]          - candidate words
//   in_sel              - index of the selected word
//   in_valid, in_ready  - input handshake
//   out_data, out_err   - selected word, in_sel >= N flag
//   out_valid, out_ready- output handshake
module muxn_pipelined
    import muxn_pipelined_pkg::*;
#(
    parameter int N                = 5,
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int SELW             = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data [N-1:0],
    input  logic [SELW-1:0]  in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int L  = clog2(N);
    localparam int S  = num_stages(N, LEVELS_PER_STAGE);
    localparam int PN = padded_n(N);

    logic [PN*WIDTH-1:0] padded;
    logic                sel_err;
    logic [S:0]          ready;

    // Padding by repeating the last input makes every sel >= N pick in_data[N-1].
    for (genvar i = 0; i < PN; i++) begin : g_pad
        localparam int SRC = (i < N) ? i : N - 1;
        assign padded[i*WIDTH +: WIDTH] = in_data[SRC];
    end

    assign sel_err  = (32'(in_sel) >= 32'(N));
    assign ready[S] = out_ready;
    assign in_ready = ready[0];

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int R      = L - k * LEVELS_PER_STAGE;   // levels still to do
        localparam int LV     = (R < LEVELS_PER_STAGE) ? R : LEVELS_PER_STAGE;
        localparam int IN_N   = 1 << R;
        localparam int OUT_N  = 1 << (R - LV);
        localparam int SW_IN  = (R < 1) ? 1 : R;
        localparam int SW_OUT = (R - LV < 1) ? 1 : R - LV;

        logic [IN_N*WIDTH-1:0]  d_in;
        logic [SW_IN-1:0]       s_in;
        logic                   e_in;
        logic                   v_in;
        logic [OUT_N*WIDTH-1:0] d_q;
        logic [SW_OUT-1:0]      s_q;
        logic                   e_q;
        logic                   v_q;

        if (k == 0) begin : g_head
            assign d_in = padded;
            assign s_in = in_sel;
            assign e_in = sel_err;
            assign v_in = in_valid;
        end else begin : g_link
            assign d_in = g_stage[k-1].d_q;
            assign s_in = g_stage[k-1].s_q;
            assign e_in = g_stage[k-1].e_q;
            assign v_in = g_stage[k-1].v_q;
        end

        muxn_pipe_stage #(
            .IN_N     (IN_N),
            .WIDTH    (WIDTH),
            .LEVELS   (LV),
            .SELW_IN  (SW_IN),
            .SELW_OUT (SW_OUT)
        ) u_stage (
            .clk      (clk),
            .arst     (arst),
            .flush    (flush),
            .up_data  (d_in),
            .up_sel   (s_in),
            .up_err   (e_in),
            .up_valid (v_in),
            .up_ready (ready[k]),
            .dn_data  (d_q),
            .dn_sel   (s_q),
            .dn_err   (e_q),
            .dn_valid (v_q),
            .dn_ready (ready[k+1])
        );
    end

    assign out_data  = g_stage[S-1].d_q;
    assign out_err   = g_stage[S-1].e_q;
    assign out_valid = g_stage[S-1].v_q;

endmodule

// File: tb/tb_muxn_pipelined.sv
// tb_muxn_pipelined: three configurations of muxn_pipelined (N=5/LPS=1,
// N=1, N=8/LPS=2). Directed latency, streaming, back-pressure, flush and
// reset sequences, then randomized traffic, all checked against a queue
// scoreboard whose expected word is derived directly from the select rule.
module tb_muxn_pipelined;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  sel = '0;
    logic [31:0] din [8];
    int          cur = 0;

    logic [31:0] d5 [4:0];
    logic [31:0] d1 [0:0];
    logic [31:0] d8 [7:0];
    always_comb begin
        for (int i = 0; i < 5; i++) d5[i] = din[i];
        for (int i = 0; i < 8; i++) d8[i] = din[i];
        d1[0] = din[0];
    end

    logic        ir5, ov5, oe5, ir1, ov1, oe1, ir8, ov8, oe8;
    logic [31:0] od5, od1, od8;

    muxn_pipelined #(.N(5), .WIDTH(32), .LEVELS_PER_STAGE(1)) dut5 (
        .clk(clk), .arst(arst), .flush(flush), .in_data(d5), .in_sel(sel),
        .in_valid(in_valid && cur == 0), .in_ready(ir5), .out_data(od5),
        .out_err(oe5), .out_valid(ov5), .out_ready(out_ready));

    muxn_pipelined #(.N(1), .WIDTH(32), .LEVELS_PER_STAGE(1)) dut1 (
        .clk(clk), .arst(arst), .flush(flush), .in_data(d1), .in_sel(sel[0]),
        .in_valid(in_valid && cur == 1), .in_ready(ir1), .out_data(od1),
        .out_err(oe1), .out_valid(ov1), .out_ready(out_ready));

    muxn_pipelined #(.N(8), .WIDTH(32), .LEVELS_PER_STAGE(2)) dut8 (
        .clk(clk), .arst(arst), .flush(flush), .in_data(d8), .in_sel(sel),
        .in_valid(in_valid && cur == 2), .in_ready(ir8), .out_data(od8),
        .out_err(oe8), .out_valid(ov8), .out_ready(out_ready));

    logic        ov_c, oe_c, ir_c;
    logic [31:0] od_c;
    always_comb begin
        case (cur)
            1:       begin ov_c = ov1; oe_c = oe1; ir_c = ir1; od_c = od1; end
            2:       begin ov_c = ov8; oe_c = oe8; ir_c = ir8; od_c = od8; end
            default: begin ov_c = ov5; oe_c = oe5; ir_c = ir5; od_c = od5; end
        endcase
    end

    function automatic int n_of(input int c);
        return (c == 1) ? 1 : (c == 2) ? 8 : 5;
    endfunction
    function automatic int s_of(input int c);
        return (c == 1) ? 1 : (c == 2) ? 2 : 3;
    endfunction

    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every accepted word, in order, until emitted or flushed.
    typedef struct packed { logic [31:0] d; logic e; } exp_t;
    exp_t        q[$];
    exp_t        px, ex;
    int          sv;
    int          n_out = 0;
    logic        hold_v = 1'b0;
    logic        hold_e;
    logic [31:0] hold_d;

    always @(negedge clk) begin
        if (arst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            // Some stage has a bubble exactly when fewer than S words are in flight.
            chk("in_ready", ir_c, out_ready || (q.size() < s_of(cur)));
            chk("ov_without_word", ov_c && q.size() == 0, 1'b0);
            if (hold_v) begin
                chk("hold_valid", ov_c, 1'b1);
                chk("hold_data", od_c, hold_d);
                chk("hold_err", oe_c, hold_e);
            end
            if (ov_c && out_ready && q.size() > 0) begin
                px = q.pop_front();
                chk("out_data", od_c, px.d);
                chk("out_err", oe_c, px.e);
                n_out++;
            end
            hold_v = ov_c && !out_ready && !flush;
            hold_d = od_c;
            hold_e = oe_c;
            if (flush) begin
                q.delete();
            end else if (in_valid && ir_c) begin
                sv   = (cur == 1) ? int'(sel[0]) : int'(sel);
                ex.d = din[(sv < n_of(cur)) ? sv : n_of(cur) - 1];
                ex.e = (sv >= n_of(cur));
                q.push_back(ex);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int c);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; arst = 1'b1; cur = c;
        cyc();
        chk("rst_valid", ov_c, 1'b0);
        chk("rst_err", oe_c, 1'b0);
        chk("rst_data", od_c, 32'h0);
        cyc();
        chk("rst_valid2", ov_c, 1'b0);
        arst = 1'b0;
        #1;
        chk("rst_ready", ir_c, 1'b1);
        cyc();
        chk("post_rst_valid", ov_c, 1'b0);
    endtask

    // Single word; counts edges from acceptance to out_valid.
    task automatic lat_chk(input string tag, input logic [2:0] s, input int lat,
                           input logic [31:0] exp_d, input logic exp_e);
        int n;
        sel = s; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n = 1;
        while (!ov_c && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, n, lat);
        chk({tag, "_data"}, od_c, exp_d);
        chk({tag, "_err"}, oe_c, exp_e);
        cyc();
    endtask

    // Back-to-back words with out_ready=1: out_valid high for exactly cnt
    // consecutive samples starting lat-1 samples after the first push.
    task automatic stream(input string tag, input int cnt, input int s0, input int lat);
        for (int i = 0; i < cnt + lat + 2; i++) begin
            in_valid = (i < cnt);
            sel = 3'(s0 + i);
            cyc();
            chk(tag, ov_c, (i >= lat - 1) && (i < cnt + lat - 1));
        end
    endtask

    task automatic rand_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in_valid  = ($urandom % 4) != 0;
            sel       = 3'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 50) == 0;
            for (int j = 0; j < 8; j++) din[j] = $urandom;
            cyc();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n0, k;
        logic saw;
        for (int j = 0; j < 8; j++) din[j] = (j < 5) ? 32'hA0 + j : 32'hEE;

        // N=5, LEVELS_PER_STAGE=1: three stages
        do_reset(0);
        lat_chk("lat5", 3'd2, 3, 32'hA2, 1'b0);
        stream("stream5", 5, 0, 3);
        stream("oor5", 3, 5, 3);
        stream("sel4", 1, 4, 3);

        // Back-pressure: 6 words, downstream stalls for 5 cycles from cycle 4.
        n0 = n_out; k = 0; saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            out_ready = !(i >= 3 && i < 8);
            in_valid  = (k < 6);
            sel       = 3'(k);
            #1;
            if (!ir_c) saw = 1'b1;
            if (in_valid && ir_c) k++;
            cyc();
        end
        chk("bp_stall_seen", saw, 1'b1);
        chk("bp_count", n_out - n0, 6);
        chk("bp_empty", q.size(), 0);

        // Flush with three words in flight.
        n0 = n_out; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sel = 3'(i);
            cyc();
        end
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_valid", ov_c, 1'b0);
        out_ready = 1'b1;
        repeat (6) cyc();
        chk("flush_drop", n_out - n0, 0);

        // Asynchronous reset between edges with three words in flight.
        n0 = n_out; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sel = 3'(i + 2);
            cyc();
        end
        in_valid = 1'b0;
        chk("pre_arst_valid", ov_c, 1'b1);
        #2 arst = 1'b1;
        #1;
        chk("arst_async_valid", ov_c, 1'b0);
        chk("arst_async_ready", ir_c, 1'b1);
        cyc();
        arst = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();
        chk("arst_drop", n_out - n0, 0);

        rand_run(400);

        // N=1: a single register stage, sel only drives err.
        do_reset(1);
        din[0] = 32'h1234_5678;
        lat_chk("lat1", 3'd0, 1, 32'h1234_5678, 1'b0);
        lat_chk("lat1_err", 3'd1, 1, 32'h1234_5678, 1'b1);
        rand_run(200);

        // N=8, LEVELS_PER_STAGE=2: two stages, exhaustive select sweep.
        do_reset(2);
        for (int j = 0; j < 8; j++) din[j] = 32'hB0 + j;
        lat_chk("lat8", 3'd7, 2, 32'hB7, 1'b0);
        stream("exh8", 8, 0, 2);
        rand_run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
